reg_file_mp: RTL and testbench

//   Parametrised multi-read-port register file for the MIPS datapath; successor to the 2R/1W file.

---
 rtl/reg_file_mp.sv | 163 ++++++++++++++++
 tb/tb_reg_file_mp.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-read-port register file: registered reads, write-first bypass, optional zero register and a
// post-reset clear sweep. Defining RF_SCOREBOARD_EN adds a per-register busy scoreboard (iss_en/iss_addr/rbusy).
module reg_file_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int NREAD    = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREAD*AW-1:0] raddr,
  output logic [NREAD*DW-1:0] rdata,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [DW-1:0]       wr_data,
`ifdef RF_SCOREBOARD_EN
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  output logic [NREAD-1:0]    rbusy,
`endif
  output logic                ready
);

  localparam logic [0:0]    ST_CLEAR = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [0:0]    state_reg, state_next;
  logic [AW-1:0] clr_cnt_reg, clr_cnt_next;
  logic          ready_reg, ready_next;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          run;
  logic          wr_ok;

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return (int'(a) < DEPTH);
  endfunction

  // An address that can hold data: in range and not the hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return addr_in_range(a) && !(ZERO_REG && (a == '0));
  endfunction

  assign run   = (state_reg == ST_RUN);
  assign wr_ok = run && wr_en && addr_live(wr_addr);
  assign ready = ready_reg;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    ready_next   = ready_reg;
    mem_we       = 1'b0;
    mem_waddr    = wr_addr;
    mem_wdata    = wr_data;
    case (state_reg)
      ST_CLEAR: begin
        mem_we       = 1'b1;
        mem_waddr    = clr_cnt_reg;
        mem_wdata    = '0;
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == LAST_IDX) begin
          state_next = ST_RUN;
          ready_next = 1'b1;
        end
      end
      default: begin
        mem_we = wr_ok;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      ready_reg   <= ready_next;
    end
  end

  // Storage is never reset directly so it can map onto block RAM; the sweep zeroes it instead.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

`ifdef RF_SCOREBOARD_EN
  logic [DEPTH-1:0] busy_reg, busy_next;
  logic             iss_ok;

  assign iss_ok = run && iss_en && addr_live(iss_addr);

  // Clear before set so a same-edge issue to the written register keeps it busy.
  always_comb begin
    busy_next = busy_reg;
    if (!run) begin
      busy_next = '0;
    end else begin
      if (wr_ok) busy_next[wr_addr] = 1'b0;
      if (iss_ok) busy_next[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end
`endif

  generate
    for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
      logic [AW-1:0] ra;
      logic [DW-1:0] rd_reg, rd_next;

      assign ra = raddr[gi*AW +: AW];

      always_comb begin
        rd_next = '0;
        if (run && addr_live(ra)) begin
          rd_next = (wr_en && (wr_addr == ra)) ? wr_data : mem[ra];
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_reg <= '0;
        end else begin
          rd_reg <= rd_next;
        end
      end

      assign rdata[gi*DW +: DW] = rd_reg;

`ifdef RF_SCOREBOARD_EN
      logic rb_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          rb_reg <= 1'b0;
        end else begin
          rb_reg <= (run && addr_in_range(ra)) ? busy_next[ra] : 1'b0;
        end
      end

      assign rbusy[gi] = rb_reg;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: a default instance (ZERO_REG=1, DEPTH=32) and a second one
// (ZERO_REG=0, DEPTH=24) driven by the same stimulus, compared against a queue-based scoreboard.
module tb_reg_file_mp;
  localparam int DW     = 32;
  localparam int AW     = 5;
  localparam int NR     = 2;
  localparam int DEP_NZ = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [NR*AW-1:0] raddr;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic [NR*DW-1:0] rdata, rdata_nz;
  logic             ready, ready_nz;
`ifdef RF_SCOREBOARD_EN
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic [NR-1:0]    rbusy, rbusy_nz;
`endif

  reg_file_mp #(.DW(DW), .DEPTH(32), .AW(AW), .NREAD(NR), .ZERO_REG(1'b1)) u_dut (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef RF_SCOREBOARD_EN
    .iss_en(iss_en), .iss_addr(iss_addr), .rbusy(rbusy),
`endif
    .ready(ready)
  );

  reg_file_mp #(.DW(DW), .DEPTH(DEP_NZ), .AW(AW), .NREAD(NR), .ZERO_REG(1'b0)) u_nz (
    .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_nz),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef RF_SCOREBOARD_EN
    .iss_en(iss_en), .iss_addr(iss_addr), .rbusy(rbusy_nz),
`endif
    .ready(ready_nz)
  );

  typedef struct {
    logic [NR*DW-1:0] rd;
    logic [NR*DW-1:0] rd_nz;
    logic [NR-1:0]    rb;
    logic [NR-1:0]    rb_nz;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] m_mem [32];
  logic [DW-1:0] m_nz  [32];
  logic [31:0]   m_busy, m_busy_nz;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_nz[i]  = '0;
    end
    m_busy    = '0;
    m_busy_nz = '0;
  endtask

  // One RUN-state transaction: drive, predict and queue, then pop and compare after the edge.
  task automatic cycle(input string tag, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                       input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic ie, input logic [AW-1:0] ia);
    exp_t          e;
    logic [31:0]   nb, nbn;
    logic [AW-1:0] a;
    @(negedge clk);
    raddr   = {a1, a0};
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
`ifdef RF_SCOREBOARD_EN
    iss_en   = ie;
    iss_addr = ia;
`endif
    nb  = m_busy;
    nbn = m_busy_nz;
    if (we && wa != 0) nb[wa] = 1'b0;
    if (we && wa < DEP_NZ) nbn[wa] = 1'b0;
    if (ie && ia != 0) nb[ia] = 1'b1;
    if (ie && ia < DEP_NZ) nbn[ia] = 1'b1;
    for (int p = 0; p < NR; p++) begin
      a = (p == 0) ? a0 : a1;
      e.rd[p*DW +: DW]    = (a == 0) ? '0 : ((we && wa == a) ? wd : m_mem[a]);
      e.rd_nz[p*DW +: DW] = (a >= DEP_NZ) ? '0 : ((we && wa == a) ? wd : m_nz[a]);
      e.rb[p]             = nb[a];
      e.rb_nz[p]          = (a < DEP_NZ) ? nbn[a] : 1'b0;
    end
    if (we && wa != 0) m_mem[wa] = wd;
    if (we && wa < DEP_NZ) m_nz[wa] = wd;
    m_busy    = nb;
    m_busy_nz = nbn;
    exp_q.push_back(e);

    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    if (rdata !== e.rd) begin
      n_err++;
      $display("FAIL %s rdata got %h want %h", tag, rdata, e.rd);
    end
    n_vec++;
    if (rdata_nz !== e.rd_nz) begin
      n_err++;
      $display("FAIL %s rdata_nz got %h want %h", tag, rdata_nz, e.rd_nz);
    end
`ifdef RF_SCOREBOARD_EN
    n_vec++;
    if (rbusy !== e.rb) begin
      n_err++;
      $display("FAIL %s rbusy got %b want %b", tag, rbusy, e.rb);
    end
    n_vec++;
    if (rbusy_nz !== e.rb_nz) begin
      n_err++;
      $display("FAIL %s rbusy_nz got %b want %b", tag, rbusy_nz, e.rb_nz);
    end
`endif
    $display("txn %s ra=%0d/%0d we=%0b wa=%0d wd=%h rdata=%h rdata_nz=%h", tag, a0, a1, we, wa, wd,
             rdata, rdata_nz);
  endtask

  // Watches DEPTH edges after rst falls; wr_en stays high for the first wr_edges of them.
  task automatic sweep_watch(input string tag, input int wr_edges);
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk);
      #1;
      n_vec++;
      if (ready !== (e >= 32)) begin
        n_err++;
        $display("FAIL %s ready edge %0d got %b want %b", tag, e, ready, (e >= 32));
      end
      n_vec++;
      if (ready_nz !== (e >= DEP_NZ)) begin
        n_err++;
        $display("FAIL %s ready_nz edge %0d got %b want %b", tag, e, ready_nz, (e >= DEP_NZ));
      end
      n_vec++;
      if (rdata !== '0) begin
        n_err++;
        $display("FAIL %s rdata edge %0d got %h want 0", tag, e, rdata);
      end
      if (e == wr_edges) wr_en = 1'b0;
    end
    $display("txn %s sweep done ready=%b ready_nz=%b", tag, ready, ready_nz);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst   = 1'b1;
    wr_en = 1'b0;
    raddr = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_vec++;
    if (ready !== 1'b0 || ready_nz !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ready got %b/%b want 0/0", ready, ready_nz);
    end
    n_vec++;
    if (rdata !== '0 || rdata_nz !== '0) begin
      n_err++;
      $display("FAIL reset_rdata got %h/%h want 0/0", rdata, rdata_nz);
    end
    @(negedge clk);
    rst = 1'b0;
    sweep_watch("sweep", 0);
    model_clear();
  endtask

  task automatic test_sweep_read();
    for (int i = 0; i < 32; i += 2) begin
      cycle("sweep_read", AW'(i), AW'(i + 1), 1'b0, '0, '0, 1'b0, '0);
    end
  endtask

  task automatic test_basic();
    cycle("basic_wr", 5'd0, 5'd1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0);
    cycle("basic_rd", 5'd5, 5'd6, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_bypass();
    cycle("bypass", 5'd7, 5'd7, 1'b1, 5'd7, 32'h12345678, 1'b0, '0);
    cycle("bypass_rd", 5'd7, 5'd5, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_zero();
    cycle("zero_bypass", 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0);
    cycle("zero_rd", 5'd0, 5'd5, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_out_of_range();
    cycle("oor_bypass", 5'd28, 5'd28, 1'b1, 5'd28, 32'h5555AAAA, 1'b0, '0);
    cycle("oor_rd", 5'd28, 5'd23, 1'b0, '0, '0, 1'b0, '0);
    cycle("edge_wr", 5'd31, 5'd23, 1'b1, 5'd23, 32'h0BADF00D, 1'b0, '0);
    cycle("edge_rd", 5'd23, 5'd31, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a0, a1, wa, ia;
    logic          we, ie;
    for (int n = 0; n < 40; n++) begin
      a0 = AW'($urandom_range(0, 31));
      a1 = AW'($urandom_range(0, 31));
      wa = AW'($urandom_range(0, 31));
      ia = AW'($urandom_range(0, 31));
      we = 1'($urandom_range(0, 1));
      ie = 1'($urandom_range(0, 1));
      if (n % 4 == 0) a1 = wa;
      cycle("b2b", a0, a1, we, wa, $urandom, ie, ia);
    end
  endtask

`ifdef RF_SCOREBOARD_EN
  task automatic test_scoreboard();
    model_clear();
    // Busy state left over from the random traffic is flushed by a fresh sweep.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sweep_watch("sb_sweep", 0);
    model_clear();
    cycle("sb_issue", 5'd9, 5'd9, 1'b0, '0, '0, 1'b1, 5'd9);
    cycle("sb_read", 5'd9, 5'd10, 1'b0, '0, '0, 1'b0, '0);
    cycle("sb_write", 5'd9, 5'd9, 1'b1, 5'd9, 32'h00000099, 1'b0, '0);
    cycle("sb_reissue", 5'd9, 5'd9, 1'b0, '0, '0, 1'b1, 5'd9);
    cycle("sb_same_edge", 5'd9, 5'd9, 1'b1, 5'd9, 32'h00000999, 1'b1, 5'd9);
    cycle("sb_hold", 5'd9, 5'd0, 1'b0, '0, '0, 1'b0, '0);
    cycle("sb_iss_r0", 5'd0, 5'd9, 1'b0, '0, '0, 1'b1, 5'd0);
  endtask
`endif

  task automatic test_mid_sweep_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst     = 1'b1;
    raddr   = {5'd3, 5'd3};
    wr_en   = 1'b1;
    wr_addr = 5'd3;
    wr_data = 32'hA5A5A5A5;
    @(posedge clk);
    #1;
    n_vec++;
    if (ready !== 1'b0 || ready_nz !== 1'b0) begin
      n_err++;
      $display("FAIL mid_rst_ready got %b/%b want 0/0", ready, ready_nz);
    end
    @(negedge clk);
    rst = 1'b0;
    sweep_watch("mid_sweep", 20);
    model_clear();
    cycle("mid_wr_ignored", 5'd3, 5'd3, 1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    rst     = 1'b1;
    raddr   = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
`ifdef RF_SCOREBOARD_EN
    iss_en   = 1'b0;
    iss_addr = '0;
`endif
    model_clear();
    test_reset();
    test_sweep_read();
    test_basic();
    test_bypass();
    test_zero();
    test_out_of_range();
    test_back_to_back();
`ifdef RF_SCOREBOARD_EN
    test_scoreboard();
`endif
    test_mid_sweep_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
